led_line_sched: RTL and testbench
=================================

# led_line_sched

Read-side line/frame scheduler for the LED PHY. It drains 12-bit pixel words from the first-word-fall-through (FWFT) async FIFO in the read clock domain. Words are issued to the LED shifter in lines of fixed length, with a blanking gap after each line and a vertical gap after the last line. It generates the FIFO read strobe, line/frame markers, and a sticky underrun flag.

## Interface
- LINE_LEN, 64, pixel words per line (≥2)
- BLANK_CYC, 8, blanking cycles after each line (≥1)
- LINES, 32, lines per frame (≥1)
- VSYNC_CYC, 16, vertical-gap cycles after the last line's blanking (≥1)
- clk  in  1  single clock, the FIFO read clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle request to run one frame; honoured only in IDLE
- fifo_valid  in  1  FWFT FIFO head word valid
- fifo_dout  in  12  FWFT FIFO head word
- fifo_re  out  1  FIFO read/pop strobe (combinational)
- pix_ready  in  1  shifter can accept a word this cycle
- pix_data  out  12  registered pixel word
- pix_vld  out  1  registered; pix_data valid for exactly one cycle
- line_start  out  1  registered one-cycle pulse on entry to LINE
- frame_done  out  1  registered one-cycle pulse on return to IDLE
- busy  out  1  state != IDLE
- line_idx  out  $clog2(LINES) (min 1)  current line number
- underrun  out  1  sticky: a word was needed but the FIFO was empty

## Operation
- States: IDLE, LINE, BLANK, VSYNC.
- IDLE: start=1 → LINE; clears word_cnt, line_idx, and underrun; pulses line_start.
- LINE:
  - fifo_re = fifo_valid & pix_ready; a transfer occurs when fifo_re=1.
  - On transfer: pix_data <= fifo_dout, pix_vld <= 1, word_cnt++.
  - No transfer → pix_vld <= 0.
  - pix_ready=1 & fifo_valid=0 → underrun <= 1; stay in LINE (stall, no word skipped).
  - pix_ready=0 → stall silently; no underrun.
  - Transfer with word_cnt==LINE_LEN-1 → BLANK; word_cnt <= 0; gap counter loaded.
- BLANK: counts BLANK_CYC cycles; fifo_re=0.
  - End, line_idx==LINES-1 → VSYNC.
  - End, otherwise → line_idx++, LINE, line_start pulse.
- VSYNC: counts VSYNC_CYC cycles; fifo_re=0. End → IDLE with frame_done pulse.
- fifo_re is 0 in every state except LINE.
- start outside IDLE is ignored. start coinciding with the frame_done cycle (already IDLE) is accepted.
- Counter widths: $clog2 of the parameter, min 1 bit; counters never wrap beyond terminal values.
- rst (any state, mid-line included): state IDLE; all counters 0; pix_data=0, pix_vld=0, line_start=0, frame_done=0, underrun=0, busy=0, line_idx=0; fifo_re=0.

## Timing
- start sampled at edge N → LINE and line_start=1 in cycle N+1; fifo_re may assert in cycle N+1.
- Word popped in cycle k → pix_vld=1 and pix_data in cycle k+1; pop-to-output latency is 1 cycle.
- Unstalled throughput is 1 word/cycle.
- Last word of a line popped in cycle k → BLANK for cycles k+1 … k+BLANK_CYC.
  - Next line: LINE and line_start in k+BLANK_CYC+1.
  - Last line: VSYNC for VSYNC_CYC cycles, then IDLE; frame_done=1 in the first IDLE cycle.
- Unstalled frame cycle count from start edge to frame_done: LINES·(LINE_LEN+BLANK_CYC)+VSYNC_CYC+1.
- underrun sets the cycle after the starving cycle and holds until rst or the next accepted start.

## Test plan
All scenarios use LINE_LEN=4, BLANK_CYC=2, LINES=2, VSYNC_CYC=3.
- Reset: rst=1 for 2 cycles, then 0 → all outputs 0, busy=0, fifo_re=0 regardless of fifo_valid/pix_ready.
- Full frame, fifo_valid=1, pix_ready=1, FIFO words 0x001..0x008, start at cycle 0:
  - fifo_re high in cycles 1–4 and 7–10.
  - pix_vld in cycles 2–5 and 8–11, carrying 0x001..0x008 in order.
  - line_start at cycles 1 and 7; frame_done at cycle 16; busy in cycles 1–15.
- Underrun: fifo_valid=0 during cycles 2–3 of line 0 → no pops there, underrun=1 from cycle 3 onward, all 8 words still delivered in order, frame_done delayed by 2 cycles.
- Backpressure: pix_ready=0 during cycles 2–4, fifo_valid=1 → fifo_re=0 and no pix_vld in those cycles, underrun stays 0, no word lost or duplicated.
- start while busy: pulse start at cycle 5 → ignored, single frame_done, line_idx sequence 0,1 only.
- Mid-line reset: rst at cycle 3 → IDLE the next cycle with all outputs 0. A new start then replays the full-frame timing with the counters freshly cleared.

Source files
------------

// File: rtl/led_line_sched.sv
// led_line_sched: drains an FWFT FIFO into fixed-length LED lines with blanking and vsync gaps
module led_line_sched #(
  parameter int LINE_LEN = 64,
  parameter int BLANK_CYC = 8,
  parameter int LINES = 32,
  parameter int VSYNC_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic fifo_valid,
  input  logic [11:0] fifo_dout,
  output logic fifo_re,
  input  logic pix_ready,
  output logic [11:0] pix_data,
  output logic pix_vld,
  output logic line_start,
  output logic frame_done,
  output logic busy,
  output logic [$clog2(LINES > 1 ? LINES : 2)-1:0] line_idx,
  output logic underrun
);
  localparam int WW = $clog2(LINE_LEN > 1 ? LINE_LEN : 2);
  localparam int GMAX = BLANK_CYC > VSYNC_CYC ? BLANK_CYC : VSYNC_CYC;
  localparam int GW = $clog2(GMAX > 1 ? GMAX : 2);
  localparam int LW = $clog2(LINES > 1 ? LINES : 2);
  typedef enum logic [1:0] {IDLE, LINE, BLANK, VSYNC} state_t;
  state_t state;
  logic [WW-1:0] word_cnt;
  logic [GW-1:0] gap_cnt;
  assign fifo_re = ~rst & (state == LINE) & fifo_valid & pix_ready;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      word_cnt <= '0;
      gap_cnt <= '0;
      line_idx <= '0;
      pix_data <= '0;
      pix_vld <= 1'b0;
      line_start <= 1'b0;
      frame_done <= 1'b0;
      underrun <= 1'b0;
    end else begin
      pix_vld <= fifo_re;
      line_start <= 1'b0;
      frame_done <= 1'b0;
      if (fifo_re) pix_data <= fifo_dout;
      case (state)
        IDLE: if (start) begin
          state <= LINE;
          word_cnt <= '0;
          line_idx <= '0;
          underrun <= 1'b0;
          line_start <= 1'b1;
        end
        LINE: begin
          if (pix_ready & ~fifo_valid) underrun <= 1'b1;
          if (fifo_re) begin
            if (word_cnt == WW'(LINE_LEN - 1)) begin
              state <= BLANK;
              word_cnt <= '0;
              gap_cnt <= '0;
            end else word_cnt <= word_cnt + 1'b1;
          end
        end
        BLANK: if (gap_cnt == GW'(BLANK_CYC - 1)) begin
          gap_cnt <= '0;
          if (line_idx == LW'(LINES - 1)) state <= VSYNC;
          else begin
            line_idx <= line_idx + 1'b1;
            state <= LINE;
            line_start <= 1'b1;
          end
        end else gap_cnt <= gap_cnt + 1'b1;
        VSYNC: if (gap_cnt == GW'(VSYNC_CYC - 1)) begin
          gap_cnt <= '0;
          state <= IDLE;
          frame_done <= 1'b1;
        end else gap_cnt <= gap_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_line_sched.sv
// tb_led_line_sched: directed frame, underrun, backpressure, busy-start and reset checks
module tb_led_line_sched;
  logic clk, rst, start, fifo_valid, pix_ready;
  logic [11:0] fifo_dout, pix_data;
  logic fifo_re, pix_vld, line_start, frame_done, busy, underrun;
  logic [0:0] line_idx;
  logic [11:0] wptr;
  int tests, fails, cyc, exp_w;
  led_line_sched #(.LINE_LEN(4), .BLANK_CYC(2), .LINES(2), .VSYNC_CYC(3)) dut (
    .clk(clk), .rst(rst), .start(start), .fifo_valid(fifo_valid), .fifo_dout(fifo_dout),
    .fifo_re(fifo_re), .pix_ready(pix_ready), .pix_data(pix_data), .pix_vld(pix_vld),
    .line_start(line_start), .frame_done(frame_done), .busy(busy), .line_idx(line_idx),
    .underrun(underrun)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) wptr <= rst ? 12'd0 : fifo_re ? wptr + 12'd1 : wptr;
  assign fifo_dout = wptr + 12'd1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic reset_dut();
    rst = 1'b1;
    start = 1'b0;
    fifo_valid = 1'b1;
    pix_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_fifo_re"}, 32'(fifo_re), 0);
    chk({tag, "_pix_vld"}, 32'(pix_vld), 0);
    chk({tag, "_pix_data"}, 32'(pix_data), 0);
    chk({tag, "_line_start"}, 32'(line_start), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_line_idx"}, 32'(line_idx), 0);
    chk({tag, "_underrun"}, 32'(underrun), 0);
  endtask
  task automatic run_frame(input string tag, input logic [31:0] re_m, input int l1, input int fd,
                           input int ur, input int vlo, input int vhi, input int rlo, input int rhi,
                           input int sb);
    logic [31:0] vld_m;
    vld_m = re_m << 1;
    exp_w = 1;
    for (int c = 0; c < 24; c++) begin
      cyc = c;
      start = (c == 0) || (c == sb);
      fifo_valid = !(c >= vlo && c <= vhi);
      pix_ready = !(c >= rlo && c <= rhi);
      #1;
      chk({tag, "_fifo_re"}, 32'(fifo_re), 32'(re_m[c]));
      chk({tag, "_pix_vld"}, 32'(pix_vld), 32'(vld_m[c]));
      chk({tag, "_line_start"}, 32'(line_start), 32'(c == 1 || c == l1));
      chk({tag, "_frame_done"}, 32'(frame_done), 32'(c == fd));
      chk({tag, "_busy"}, 32'(busy), 32'(c >= 1 && c < fd));
      chk({tag, "_underrun"}, 32'(underrun), 32'(c >= ur));
      chk({tag, "_line_idx"}, 32'(line_idx), 32'(c >= l1));
      if (pix_vld) begin
        chk({tag, "_pix_data"}, 32'(pix_data), 32'(exp_w));
        exp_w++;
      end
      tick();
    end
    start = 1'b0;
    chk({tag, "_word_count"}, 32'(exp_w), 9);
  endtask
  initial begin
    tests = 0;
    fails = 0;
    cyc = 0;
    reset_dut();
    #1;
    chk_idle("reset");
    run_frame("full", 32'h0000_079E, 7, 16, 99, -1, -1, -1, -1, -1);
    reset_dut();
    run_frame("underrun", 32'h0000_1E72, 9, 18, 3, 2, 3, -1, -1, -1);
    reset_dut();
    run_frame("backpressure", 32'h0000_3CE2, 10, 19, 99, -1, -1, 2, 4, -1);
    reset_dut();
    run_frame("busy_start", 32'h0000_079E, 7, 16, 99, -1, -1, -1, -1, 5);
    reset_dut();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc = 4;
    #1;
    chk_idle("midreset");
    run_frame("replay", 32'h0000_079E, 7, 16, 99, -1, -1, -1, -1, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
